// File: rtl/gtx_sync_pkg.sv
// Shared definitions for the GTX word-sync controller: state encodings,
// statistics width and a constant-friendly clog2.
package gtx_sync_pkg;

  typedef enum logic [1:0] {
    LOS   = 2'd0,
    ACQ   = 2'd1,
    SYNC  = 2'd2,
    CHECK = 2'd3
  } sync_state_e;

  localparam int STAT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gtx_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module gtx_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gtx_comma_sync_ctrl.sv
// Receive word-sync FSM (LOS/ACQ/SYNC/CHECK) driven by aligner commas and
// decode errors. Optional link statistics under GTX_SYNC_STATS_EN.
module gtx_comma_sync_ctrl
  import gtx_sync_pkg::*;
#(
  parameter int COMMA_LOCK_CNT = 3,
  parameter int ERR_LIMIT      = 4,
  parameter int GOOD_RUN       = 16,
  parameter int COMMA_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              comma,
  input  logic              realign,
  input  logic              dec_err,
  output logic              synced,
  output logic [1:0]        state,
  output logic              align_en,
  output logic              realign_err,
  output logic [STAT_W-1:0] stat_realign,
  output logic [STAT_W-1:0] stat_loss
);

  localparam int CC_W  = clog2(COMMA_LOCK_CNT) + 1;
  localparam int EC_W  = clog2(ERR_LIMIT) + 1;
  localparam int GC_W  = clog2(GOOD_RUN) + 1;
  localparam int TMR_W = clog2(COMMA_TIMEOUT) + 1;

  localparam logic [CC_W-1:0]  CC_LOCK = CC_W'(COMMA_LOCK_CNT);
  localparam logic [EC_W-1:0]  EC_LIM  = EC_W'(ERR_LIMIT);
  localparam logic [GC_W-1:0]  GC_RUN  = GC_W'(GOOD_RUN);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(COMMA_TIMEOUT - 1);

  sync_state_e      state_q, state_d;
  logic [CC_W-1:0]  comma_cnt_q, comma_cnt_d, comma_inc;
  logic [EC_W-1:0]  err_cnt_q, err_cnt_d, err_inc, err_dec;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d, good_inc;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             realign_err_q, realign_err_d;
  logic             err_in, expire;

  always_comb begin
    state_d       = state_q;
    comma_cnt_d   = comma_cnt_q;
    err_cnt_d     = err_cnt_q;
    good_cnt_d    = good_cnt_q;
    err_in        = dec_err | realign;
    comma_inc     = comma_cnt_q + 1'b1;
    err_inc       = err_cnt_q + 1'b1;
    err_dec       = err_cnt_q - 1'b1;
    good_inc      = good_cnt_q + 1'b1;
    realign_err_d = realign & state_q[1];
    // Timer parks at its limit so it never wraps while idling in LOS.
    timer_d = comma ? '0 : ((timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1);
    expire  = !comma && (timer_q == TMR_MAX) && (state_q != LOS);

    case (state_q)
      LOS: begin
        if (comma && !dec_err) begin
          if (COMMA_LOCK_CNT == 1) state_d = SYNC;
          else begin
            state_d     = ACQ;
            comma_cnt_d = CC_W'(1);
          end
        end
      end
      ACQ: begin
        if (err_in) state_d = LOS;
        else if (comma) begin
          comma_cnt_d = comma_inc;
          if (comma_inc == CC_LOCK) state_d = SYNC;
        end
      end
      SYNC: begin
        if (err_in) begin
          state_d    = CHECK;
          err_cnt_d  = EC_W'(1);
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (err_in) begin
          err_cnt_d  = err_inc;
          good_cnt_d = '0;
          if (err_inc == EC_LIM) state_d = LOS;
        end else if (good_inc == GC_RUN) begin
          good_cnt_d = '0;
          err_cnt_d  = err_dec;
          if (err_dec == '0) state_d = SYNC;
        end else begin
          good_cnt_d = good_inc;
        end
      end
      default: state_d = LOS;
    endcase

    if (expire) state_d = LOS;
    if (state_d == LOS) begin
      comma_cnt_d = '0;
      err_cnt_d   = '0;
      good_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOS;
      comma_cnt_q   <= '0;
      err_cnt_q     <= '0;
      good_cnt_q    <= '0;
      timer_q       <= '0;
      realign_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      comma_cnt_q   <= comma_cnt_d;
      err_cnt_q     <= err_cnt_d;
      good_cnt_q    <= good_cnt_d;
      timer_q       <= timer_d;
      realign_err_q <= realign_err_d;
    end
  end

  assign state       = state_q;
  assign synced      = state_q[1];
  assign align_en    = ~state_q[1];
  assign realign_err = realign_err_q;

`ifdef GTX_SYNC_STATS_EN
  logic loss;
  assign loss = state_q[1] && (state_d == LOS);

  gtx_sat_cnt #(.W(STAT_W)) u_stat_realign (
    .clk (clk),
    .clr (rst),
    .inc (realign_err_d),
    .cnt (stat_realign)
  );

  gtx_sat_cnt #(.W(STAT_W)) u_stat_loss (
    .clk (clk),
    .clr (rst),
    .inc (loss),
    .cnt (stat_loss)
  );
`else
  assign stat_realign = '0;
  assign stat_loss    = '0;
`endif

endmodule

// File: tb/tb_gtx_comma_sync_ctrl.sv
// Directed bench for gtx_comma_sync_ctrl: a vector table for the main FSM
// walk plus hand-written timeout and reset sequences.
module tb_gtx_comma_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst, comma, realign, dec_err;
  logic        synced, align_en, realign_err;
  logic [1:0]  state;
  logic [15:0] stat_realign, stat_loss;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       c, r, e;
    logic [1:0] st;
    logic       rerr;
  } vec_t;

  vec_t vecs[$];

  gtx_comma_sync_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .comma        (comma),
    .realign      (realign),
    .dec_err      (dec_err),
    .synced       (synced),
    .state        (state),
    .align_en     (align_en),
    .realign_err  (realign_err),
    .stat_realign (stat_realign),
    .stat_loss    (stat_loss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks the full registered output set against an expected state.
  task automatic chk_state(input string name, input logic [1:0] st, input logic rerr);
    chk(name, {27'd0, state, synced, align_en, realign_err},
              {27'd0, st, st[1], ~st[1], rerr});
  endtask

  task automatic step(input logic c, input logic r, input logic e);
    comma = c; realign = r; dec_err = e;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic c, input logic r, input logic e,
                     input logic [1:0] st, input logic rerr);
    vec_t v;
    v.c = c; v.r = r; v.e = e; v.st = st; v.rerr = rerr;
    vecs.push_back(v);
  endtask

  task automatic chk_stats(input string name, input int exp_ra, input int exp_ls);
`ifdef GTX_SYNC_STATS_EN
    chk({name, " stat_realign"}, {16'd0, stat_realign}, exp_ra);
    chk({name, " stat_loss"},    {16'd0, stat_loss},    exp_ls);
`else
    chk({name, " stat_realign"}, {16'd0, stat_realign}, 32'd0);
    chk({name, " stat_loss"},    {16'd0, stat_loss},    32'd0);
    if (exp_ra < 0 || exp_ls < 0) chk("stats arg", 32'd1, 32'd0);
`endif
  endtask

  initial begin
    // LOS: comma with decode error is rejected.
    add(1,0,1, 2'd0, 0);
    add(0,0,0, 2'd0, 0);
    // Three commas 4 cycles apart: LOS -> ACQ -> ACQ -> SYNC.
    add(1,0,0, 2'd1, 0);
    for (int i = 0; i < 3; i++) add(0,0,0, 2'd1, 0);
    add(1,0,0, 2'd1, 0);
    for (int i = 0; i < 3; i++) add(0,0,0, 2'd1, 0);
    add(1,0,0, 2'd2, 0);
    // SYNC realign: one-cycle realign_err, CHECK, recovers after 16 good words.
    add(0,1,0, 2'd3, 1);
    for (int i = 0; i < 15; i++) add(i % 4 == 0, 0, 0, 2'd3, 0);
    add(1,0,0, 2'd2, 0);
    // Two errors separated by a partial run: needs 32 good words to recover.
    add(0,0,1, 2'd3, 0);
    for (int i = 0; i < 5; i++) add(0,0,0, 2'd3, 0);
    add(1,0,1, 2'd3, 0);
    for (int i = 0; i < 31; i++) add(i % 4 == 0, 0, 0, 2'd3, 0);
    add(1,0,0, 2'd2, 0);
    // ERR_LIMIT consecutive errors drop to LOS.
    add(0,0,1, 2'd3, 0);
    add(0,0,1, 2'd3, 0);
    add(0,0,1, 2'd3, 0);
    add(1,0,1, 2'd0, 0);
    // ACQ realign aborts; a fresh 3 commas are then required.
    add(1,0,0, 2'd1, 0);
    add(1,0,0, 2'd1, 0);
    add(0,1,0, 2'd0, 0);
    add(1,0,0, 2'd1, 0);
    add(1,0,0, 2'd1, 0);
    add(1,0,0, 2'd2, 0);

    rst = 1'b1; comma = 0; realign = 0; dec_err = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_state("reset", 2'd0, 0);
    chk_stats("reset", 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].r, vecs[i].e);
      chk_state($sformatf("row %0d", i), vecs[i].st, vecs[i].rerr);
    end
    chk_stats("after table", 1, 1);

    // Timeout: 1024 comma-free cycles in SYNC drop to LOS.
    for (int i = 0; i < 1023; i++) step(0,0,0);
    chk_state("pre-timeout", 2'd2, 0);
    step(0,0,0);
    chk_state("timeout", 2'd0, 0);
    chk_stats("timeout", 1, 2);

    // Comma on the expiry cycle keeps SYNC and restarts the timer.
    step(1,0,0); step(1,0,0); step(1,0,0);
    chk_state("relock", 2'd2, 0);
    for (int i = 0; i < 1023; i++) step(0,0,0);
    step(1,0,0);
    chk_state("comma on expiry", 2'd2, 0);
    for (int i = 0; i < 1023; i++) step(0,0,0);
    chk_state("timer restarted", 2'd2, 0);
    step(0,0,0);
    chk_state("second timeout", 2'd0, 0);

    // Reset mid-CHECK with all inputs active.
    step(1,0,0); step(1,0,0); step(1,0,0);
    step(0,0,1);
    chk_state("into check", 2'd3, 0);
    rst = 1'b1;
    step(1,1,1);
    chk_state("mid reset", 2'd0, 0);
    chk_stats("mid reset", 0, 0);
    rst = 1'b0;
    step(0,0,0);
    chk_state("after reset", 2'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
